// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit.
//   - E/M operand forwarding per source operand (E has priority over M)
//   - load-use stall against the E-stage load
//   - one-entry scoreboard for a single long-latency unit (MDU) that stalls
//     decode on RAW / WAW against the in-flight op and on structural conflicts
// Optional build macro: HAZARD_PERF_EN adds saturating stall-cycle counters;
// without it the perf ports are tied to 0 and no counter flops exist.
//
// Handshake: stall is the only flow-control signal. While stall is high the
// decode slot must be held unchanged and a bubble injected into E; an
// instruction leaves decode on any cycle with D_valid && !flush && !stall.
// The scoreboard state (busy, long_rd) is exported directly for observation.
module hazard_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int LONG_LAT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      D_valid,
  input  logic [NUM_SRC*REG_W-1:0]  D_src,
  input  logic                      D_we,
  input  logic [REG_W-1:0]          D_rd,
  input  logic                      D_is_long,
  input  logic                      flush,
  input  logic                      E_is_load,
  input  logic [REG_W-1:0]          E_rd,
  input  logic [REG_W-1:0]          M_rd,
  input  logic [DATA_W-1:0]         E_out,
  input  logic [DATA_W-1:0]         M_out,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        fw_en,
  output logic [NUM_SRC*DATA_W-1:0] fw_data,
  output logic                      busy,
  output logic [REG_W-1:0]          long_rd,
  output logic [31:0]               perf_load_stalls,
  output logic [31:0]               perf_long_stalls
);

  localparam int CNT_W = $clog2(LONG_LAT + 1);

  // Scoreboard state for the single in-flight long op.
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [REG_W-1:0] r_long_rd;

  // Per-operand match vectors; register 0 never matches anything.
  logic [NUM_SRC-1:0] w_e_hit;
  logic [NUM_SRC-1:0] w_m_hit;
  logic [NUM_SRC-1:0] w_l_hit;

  logic w_active;
  logic w_load_hz;
  logic w_raw_hz;
  logic w_waw_hz;
  logic w_struct_hz;
  logic w_stall;
  logic w_issue;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_op
      logic [REG_W-1:0] w_s;
      assign w_s     = D_src[g*REG_W +: REG_W];
      assign w_e_hit[g] = (w_s != '0) && (w_s == E_rd);
      assign w_m_hit[g] = (w_s != '0) && (w_s == M_rd);
      assign w_l_hit[g] = (w_s != '0) && (w_s == r_long_rd);
      assign fw_en[g]   = w_e_hit[g] | w_m_hit[g];
      // E wins over M when both stages target the same register.
      assign fw_data[g*DATA_W +: DATA_W] = (w_s == E_rd) ? E_out : M_out;
    end
  endgenerate

  // Hazard terms; all suppressed when the decode slot is empty or flushed.
  always_comb begin
    w_active    = D_valid && !flush;
    w_load_hz   = w_active && E_is_load && (E_rd != '0) && (|w_e_hit);
    w_raw_hz    = w_active && r_busy && (r_long_rd != '0) && (|w_l_hit);
    w_waw_hz    = w_active && r_busy && D_we && (D_rd != '0) && (D_rd == r_long_rd);
    // Uses registered busy, so a new long op waits one cycle after completion.
    w_struct_hz = w_active && r_busy && D_is_long;
    w_stall     = w_load_hz | w_raw_hz | w_waw_hz | w_struct_hz;
    w_issue     = w_active && D_is_long && !w_stall;
  end

  assign stall   = w_stall;
  assign busy    = r_busy;
  assign long_rd = r_long_rd;

  // Long-op scoreboard: load on issue, count down, clear after the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_long_rd <= '0;
    end else if (w_issue) begin
      r_busy    <= 1'b1;
      r_cnt     <= CNT_W'(LONG_LAT);
      r_long_rd <= D_we ? D_rd : '0;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(1)) begin
        r_busy    <= 1'b0;
        r_cnt     <= '0;
        r_long_rd <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_load;
  logic [31:0] r_perf_long;

  // Saturating stall-cycle counters; load-use takes precedence in attribution.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_load <= '0;
      r_perf_long <= '0;
    end else begin
      if (w_stall && w_load_hz && (r_perf_load != 32'hFFFF_FFFF))
        r_perf_load <= r_perf_load + 32'd1;
      if (w_stall && !w_load_hz && (w_raw_hz | w_waw_hz | w_struct_hz) &&
          (r_perf_long != 32'hFFFF_FFFF))
        r_perf_long <= r_perf_long + 32'd1;
    end
  end

  assign perf_load_stalls = r_perf_load;
  assign perf_long_stalls = r_perf_long;
`else
  assign perf_load_stalls = 32'd0;
  assign perf_long_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: table of combinational vectors, hand
// sequences for the multi-cycle scoreboard cases, then randomized stimulus
// against a cycle-stamp reference model.
module tb_hazard_scoreboard;

  localparam int NS = 2;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int LL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               D_valid;
  logic [NS*RW-1:0]   D_src;
  logic               D_we;
  logic [RW-1:0]      D_rd;
  logic               D_is_long;
  logic               flush;
  logic               E_is_load;
  logic [RW-1:0]      E_rd;
  logic [RW-1:0]      M_rd;
  logic [DW-1:0]      E_out;
  logic [DW-1:0]      M_out;
  logic               stall;
  logic [NS-1:0]      fw_en;
  logic [NS*DW-1:0]   fw_data;
  logic               busy;
  logic [RW-1:0]      long_rd;
  logic [31:0]        perf_load_stalls;
  logic [31:0]        perf_long_stalls;

  hazard_scoreboard #(
    .NUM_SRC(NS), .REG_W(RW), .DATA_W(DW), .LONG_LAT(LL)
  ) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_src(D_src), .D_we(D_we),
    .D_rd(D_rd), .D_is_long(D_is_long), .flush(flush), .E_is_load(E_is_load),
    .E_rd(E_rd), .M_rd(M_rd), .E_out(E_out), .M_out(M_out), .stall(stall),
    .fw_en(fw_en), .fw_data(fw_data), .busy(busy), .long_rd(long_rd),
    .perf_load_stalls(perf_load_stalls), .perf_long_stalls(perf_long_stalls)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_valid = 0; D_src = '0; D_we = 0; D_rd = '0; D_is_long = 0; flush = 0;
    E_is_load = 0; E_rd = '0; M_rd = '0; E_out = '0; M_out = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [NS*RW-1:0] src;
    logic          we;
    logic [RW-1:0] rd;
    logic          fl;
    logic          eload;
    logic [RW-1:0] erd;
    logic [RW-1:0] mrd;
    logic [DW-1:0] eout;
    logic [DW-1:0] mout;
    logic          x_stall;
    logic [NS-1:0] x_fwen;
    logic [NS*DW-1:0] x_fwdata;
  } vec_t;

  vec_t vecs[8];

  // ---------------- reference model ----------------
  // The long op is remembered by the cycle index it left decode in; it is
  // busy for cycles issue+1 .. issue+LL.
  int          m_cyc;
  bit          m_has;
  int          m_issue;
  logic [RW-1:0] m_rd;
  logic [31:0] m_pload;
  logic [31:0] m_plong;

  function automatic bit m_busy();
    int d;
    d = m_cyc - m_issue;
    return m_has && (d >= 1) && (d <= LL);
  endfunction

  task automatic model_step_and_check();
    bit            b, act, lh, rh, wh, sh, st, iss;
    logic [RW-1:0] lrd, s;
    logic [NS-1:0] xen;
    logic [NS*DW-1:0] xdata;
    b   = m_busy();
    lrd = b ? m_rd : '0;
    act = D_valid && !flush;
    lh = 0; rh = 0; xen = '0; xdata = '0;
    for (int i = 0; i < NS; i++) begin
      s = D_src[i*RW +: RW];
      if (s != 0 && s == E_rd && E_is_load) lh = 1;
      if (s != 0 && b && s == lrd) rh = 1;
      xen[i] = (s != 0) && (s == E_rd || s == M_rd);
      xdata[i*DW +: DW] = (s == E_rd) ? E_out : M_out;
    end
    lh  = lh && act;
    rh  = rh && act;
    wh  = act && b && D_we && D_rd != 0 && D_rd == lrd;
    sh  = act && b && D_is_long;
    st  = lh || rh || wh || sh;
    iss = act && D_is_long && !st;
    chk("rnd_stall", 64'(stall), 64'(st));
    chk("rnd_fw_en", 64'(fw_en), 64'(xen));
    chk("rnd_fw_data", fw_data, xdata);
    chk("rnd_busy", 64'(busy), 64'(b));
    chk("rnd_long_rd", 64'(long_rd), 64'(lrd));
    chk("rnd_perf_load", 64'(perf_load_stalls), 64'(perf_exp(m_pload)));
    chk("rnd_perf_long", 64'(perf_long_stalls), 64'(perf_exp(m_plong)));
    if (reset) begin
      m_has = 0; m_pload = 0; m_plong = 0;
    end else begin
      if (iss) begin
        m_has = 1; m_issue = m_cyc; m_rd = D_we ? D_rd : '0;
      end
      if (lh && m_pload != 32'hFFFF_FFFF) m_pload++;
      else if (!lh && (rh || wh || sh) && m_plong != 32'hFFFF_FFFF) m_plong++;
    end
    m_cyc++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_long_rd", 64'(long_rd), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_perf_load", 64'(perf_load_stalls), 64'd0);
    chk("rst_perf_long", 64'(perf_long_stalls), 64'd0);

    // v, src{op1,op0}, we, rd, fl, eload, erd, mrd, eout, mout, stall, fwen, fwdata{op1,op0}
    vecs[0] = '{1, {5'd3, 5'd3}, 0, 5'd0, 0, 0, 5'd3, 5'd3, 32'hAAAA, 32'h5555, 0, 2'b11, {32'hAAAA, 32'hAAAA}};
    vecs[1] = '{1, {5'd7, 5'd2}, 0, 5'd0, 0, 1, 5'd7, 5'd0, 32'h1111, 32'h2222, 1, 2'b10, {32'h1111, 32'h2222}};
    vecs[2] = '{1, {5'd7, 5'd2}, 0, 5'd0, 0, 1, 5'd0, 5'd0, 32'h1111, 32'h2222, 0, 2'b00, {32'h2222, 32'h2222}};
    vecs[3] = '{1, {5'd4, 5'd5}, 0, 5'd0, 0, 0, 5'd4, 5'd5, 32'h1234, 32'h9876, 0, 2'b11, {32'h1234, 32'h9876}};
    vecs[4] = '{1, {5'd0, 5'd0}, 0, 5'd0, 0, 1, 5'd0, 5'd0, 32'hBEEF, 32'hCAFE, 0, 2'b00, {32'hBEEF, 32'hBEEF}};
    vecs[5] = '{1, {5'd1, 5'd7}, 0, 5'd0, 1, 1, 5'd7, 5'd0, 32'h0F0F, 32'hF0F0, 0, 2'b01, {32'hF0F0, 32'h0F0F}};
    vecs[6] = '{0, {5'd7, 5'd7}, 0, 5'd0, 0, 1, 5'd7, 5'd0, 32'h3333, 32'h4444, 0, 2'b11, {32'h3333, 32'h3333}};
    vecs[7] = '{1, {5'd6, 5'd8}, 1, 5'd9, 0, 1, 5'd2, 5'd8, 32'h5A5A, 32'hA5A5, 0, 2'b01, {32'hA5A5, 32'hA5A5}};

    for (int k = 0; k < 8; k++) begin
      D_valid = vecs[k].v; D_src = vecs[k].src; D_we = vecs[k].we; D_rd = vecs[k].rd;
      D_is_long = 0; flush = vecs[k].fl; E_is_load = vecs[k].eload;
      E_rd = vecs[k].erd; M_rd = vecs[k].mrd; E_out = vecs[k].eout; M_out = vecs[k].mout;
      #1;
      chk($sformatf("vec%0d_stall", k), 64'(stall), 64'(vecs[k].x_stall));
      chk($sformatf("vec%0d_fw_en", k), 64'(fw_en), 64'(vecs[k].x_fwen));
      chk($sformatf("vec%0d_fw_data", k), fw_data, vecs[k].x_fwdata);
    end

    // Long RAW: issue to r9, dependent reader stalls exactly LL cycles.
    idle_inputs();
    do_reset();
    D_valid = 1; D_is_long = 1; D_we = 1; D_rd = 5'd9;
    #1;
    chk("raw_issue_stall", 64'(stall), 64'd0);
    tick();
    D_is_long = 0; D_we = 0; D_rd = '0; D_src = {5'd0, 5'd9};
    for (int c = 1; c <= LL; c++) begin
      #1;
      chk($sformatf("raw_c%0d_stall", c), 64'(stall), 64'd1);
      chk($sformatf("raw_c%0d_busy", c), 64'(busy), 64'd1);
      chk($sformatf("raw_c%0d_long_rd", c), 64'(long_rd), 64'd9);
      tick();
    end
    #1;
    chk("raw_done_stall", 64'(stall), 64'd0);
    chk("raw_done_busy", 64'(busy), 64'd0);
    chk("raw_done_long_rd", 64'(long_rd), 64'd0);
    chk("raw_perf_long", 64'(perf_long_stalls), 64'(perf_exp(32'd4)));
    chk("raw_perf_load", 64'(perf_load_stalls), 64'd0);
    D_valid = 0;
    tick();

    // Structural / WAW / flush / reset mid-op.
    idle_inputs();
    do_reset();
    D_valid = 1; D_is_long = 1; D_we = 1; D_rd = 5'd9;
    tick();
    D_we = 0; D_rd = '0;
    #1;
    chk("struct_stall", 64'(stall), 64'd1);
    D_is_long = 0; D_we = 1; D_rd = 5'd9;
    #1;
    chk("waw_stall", 64'(stall), 64'd1);
    D_rd = 5'd10; D_src = {5'd1, 5'd2};
    #1;
    chk("nowaw_stall", 64'(stall), 64'd0);
    D_we = 0; D_rd = '0; D_src = {5'd0, 5'd9}; D_is_long = 1; flush = 1;
    #1;
    chk("flush_stall", 64'(stall), 64'd0);
    tick();
    flush = 0; D_is_long = 0;
    #1;
    chk("flush_busy", 64'(busy), 64'd1);
    chk("flush_long_rd", 64'(long_rd), 64'd9);
    chk("pre_rst_stall", 64'(stall), 64'd1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_long_rd", 64'(long_rd), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_perf_load", 64'(perf_load_stalls), 64'd0);
    chk("midrst_perf_long", 64'(perf_long_stalls), 64'd0);

    // A flushed long op in an idle unit must not issue.
    D_src = '0; D_is_long = 1; D_we = 1; D_rd = 5'd5; flush = 1;
    #1;
    chk("flush_idle_stall", 64'(stall), 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_long_rd", 64'(long_rd), 64'd0);

    // Randomized run against the reference model.
    do_reset();
    m_cyc = 0; m_has = 0; m_issue = 0; m_rd = '0; m_pload = 0; m_plong = 0;
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      D_valid   = ($urandom_range(0, 9) < 8);
      D_src     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      D_we      = ($urandom_range(0, 1) == 1);
      D_rd      = 5'($urandom_range(0, 3));
      D_is_long = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 9) == 0);
      E_is_load = ($urandom_range(0, 9) < 3);
      E_rd      = 5'($urandom_range(0, 3));
      M_rd      = 5'($urandom_range(0, 3));
      E_out     = $urandom;
      M_out     = $urandom;
      #1;
      model_step_and_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Decode-stage hazard unit for the in-order pipeline, generalised to a configurable number of source operands and data width. Keeps the E/M forwarding and load-use stall behaviour and adds a one-entry scoreboard for a single long-latency unit (MDU). The scoreboard stalls decode on RAW/WAW hazards against the in-flight long op and on structural conflicts. Sits between decode and the register-file/operand muxes and drives the pipeline stall.

Parameters:
NUM_SRC, 2, number of source-register operands checked per decoded instruction (>=1)
REG_W, 5, register index width; index 0 is the hardwired zero register
DATA_W, 32, forwarded data width
LONG_LAT, 4, cycles from long-op issue until its result is in the register file (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
D_valid  in  1  decode slot holds a real instruction
D_src  in  NUM_SRC*REG_W  packed source indices, operand i at bits [i*REG_W +: REG_W]
D_we  in  1  decoded instruction writes D_rd
D_rd  in  REG_W  decoded destination register
D_is_long  in  1  decoded instruction issues to the long-latency unit
flush  in  1  squash the decode instruction this cycle
E_is_load  in  1  E-stage instruction is a load
E_rd, M_rd  in  REG_W  E/M destination registers (0 = no write)
E_out, M_out  in  DATA_W  E/M result values
stall  out  1  hold F/D, inject bubble into E
fw_en  out  NUM_SRC  operand i takes fw_data instead of the register file
fw_data  out  NUM_SRC*DATA_W  forwarded value per operand, same packing as D_src
busy  out  1  long op in flight
long_rd  out  REG_W  destination of the in-flight long op
perf_load_stalls, perf_long_stalls  out  32  stall-cycle counters (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high. Reset clears busy, cnt, long_rd and the perf counters to 0. Combinational outputs settle from inputs in the same cycle.
- Forwarding (combinational, per operand i, src = D_src[i]):
  - fw_en[i] = src != 0 && (src == E_rd || src == M_rd).
  - fw_data[i] = E_out if src == E_rd, else M_out. E wins when both match.
- Hazard terms (all gated by D_valid && !flush):
  - load_hz: E_is_load && E_rd != 0 && any src == E_rd.
  - raw_hz: busy && long_rd != 0 && any src == long_rd.
  - waw_hz: busy && D_we && D_rd != 0 && D_rd == long_rd.
  - struct_hz: busy && D_is_long.
- stall = load_hz | raw_hz | waw_hz | struct_hz.
- Issue: issue = D_valid && !flush && D_is_long && !stall.
  - On issue: busy <= 1, cnt <= LONG_LAT, long_rd <= (D_we ? D_rd : 0).
- Countdown: while busy and not issuing, cnt decrements each cycle. When cnt == 1, the next edge clears busy, cnt and long_rd to 0.
  - For an issue at edge t, busy is high for exactly LONG_LAT cycles.
  - A dependent instruction issues LONG_LAT+1 cycles after the long op leaves decode.
- Completion and a new long op in the same cycle: struct_hz uses registered busy, so the new op stalls one cycle, then issues. No back-to-back overlap.
- flush: suppresses all hazard terms and issue for that cycle only. An already-issued long op keeps counting and is never cancelled.
- Reset mid-operation: the in-flight long op is forgotten and stall drops the same cycle (combinational from cleared state).
- Register 0 never causes a hazard or forwarding.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_load_stalls increments on each cycle with stall && load_hz.
  - perf_long_stalls increments on each cycle with stall && !load_hz && (raw_hz|waw_hz|struct_hz).
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. The hazard logic is identical either way.

Test Plan:
- Forwarding priority: D_src={r3,r3}, E_rd=3, M_rd=3, E_out=0xAAAA, M_out=0x5555 -> fw_en=2'b11, both fw_data=0xAAAA, stall=0.
- Load-use: E_is_load=1, E_rd=7, D_src[1]=7, D_valid=1 -> stall=1. Same with E_rd=0 -> stall=0, fw_en=0.
- Long RAW, LONG_LAT=4: issue long op to r9 at edge 0, then D_src[0]=9 held -> stall=1 for cycles 1..4, 0 in cycle 5. busy goes 1->0 after edge 4.
- Structural/WAW: busy with long_rd=9 -> second D_is_long stalls; D_we=1, D_rd=9 stalls; D_rd=10 with no src match does not stall.
- flush: busy, D_src[0]=long_rd, flush=1 -> stall=0, no issue, busy unaffected.
- Reset mid-op: assert reset at cycle 2 of a long op -> next cycle busy=0, long_rd=0, stall=0. With HAZARD_PERF_EN, counters read 0 after reset and count exact stall cycles in the earlier scenarios (e.g. perf_long_stalls=4 after the RAW test).
